// File: rtl/wash_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : wash_phase_sequencer
// Description : Sequences one wash cycle (FILL, WASH, RINSE, DRAIN, SPIN,
//               DONE) on a tick timebase, with pause, abort and periodic
//               motor reversal. Drives PWM duty/direction, valve and pump.
// Revision    : 1.0 - initial release
// ============================================================================
module wash_phase_sequencer #(
   parameter int TW        = 16,
   parameter int FILL_T    = 100,
   parameter int WASH_T    = 300,
   parameter int RINSE_T   = 200,
   parameter int DRAIN_T   = 100,
   parameter int SPIN_T    = 150,
   parameter int REV_T     = 50,
   parameter int WASH_DUTY = 128,
   parameter int SPIN_DUTY = 230
) (
   input  logic       sysclk,
   input  logic       rst_n,
   input  logic       i_tick,
   input  logic       i_start,
   input  logic       i_pause,
   input  logic       i_abort,
   output logic [2:0] o_phase,
   output logic [7:0] o_duty,
   output logic       o_dir,
   output logic       o_valve,
   output logic       o_pump,
   output logic       o_busy,
   output logic       o_done
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FILL  = 3'd1;
   localparam logic [2:0] ST_WASH  = 3'd2;
   localparam logic [2:0] ST_RINSE = 3'd3;
   localparam logic [2:0] ST_DRAIN = 3'd4;
   localparam logic [2:0] ST_SPIN  = 3'd5;
   localparam logic [2:0] ST_DONE  = 3'd6;

   // Terminal timer value for a duration; a duration of 0 behaves like 1.
   function automatic logic [TW-1:0] last_of(input int dur);
      if (dur <= 1) return '0;
      return TW'(dur - 1);
   endfunction

   localparam logic [TW-1:0] FILL_LAST  = last_of(FILL_T);
   localparam logic [TW-1:0] WASH_LAST  = last_of(WASH_T);
   localparam logic [TW-1:0] RINSE_LAST = last_of(RINSE_T);
   localparam logic [TW-1:0] DRAIN_LAST = last_of(DRAIN_T);
   localparam logic [TW-1:0] SPIN_LAST  = last_of(SPIN_T);
   localparam logic [TW-1:0] REV_LAST   = last_of(REV_T);
   localparam logic [7:0]    WASH_PWM   = 8'(WASH_DUTY);
   localparam logic [7:0]    SPIN_PWM   = 8'(SPIN_DUTY);

   logic [2:0]    state, state_nx;
   logic [TW-1:0] phase_tmr, phase_tmr_nx;
   logic [TW-1:0] rev_tmr, rev_tmr_nx;
   logic          dir, dir_nx;
   logic          coast, coast_nx;
   logic          abort_flag, abort_flag_nx;

   logic [TW-1:0] phase_last;
   logic          counted;
   logic          active;

   logic [7:0]    duty_nx;
   logic          dir_out_nx;
   logic          valve_nx;
   logic          pump_nx;
   logic          busy_nx;
   logic          done_nx;

   // State, timers, flags and the registered outputs.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         phase_tmr  <= '0;
         rev_tmr    <= '0;
         dir        <= 1'b0;
         coast      <= 1'b0;
         abort_flag <= 1'b0;
         o_phase    <= 3'd0;
         o_duty     <= 8'd0;
         o_dir      <= 1'b0;
         o_valve    <= 1'b0;
         o_pump     <= 1'b0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
      end else begin
         state      <= state_nx;
         phase_tmr  <= phase_tmr_nx;
         rev_tmr    <= rev_tmr_nx;
         dir        <= dir_nx;
         coast      <= coast_nx;
         abort_flag <= abort_flag_nx;
         o_phase    <= state_nx;
         o_duty     <= duty_nx;
         o_dir      <= dir_out_nx;
         o_valve    <= valve_nx;
         o_pump     <= pump_nx;
         o_busy     <= busy_nx;
         o_done     <= done_nx;
      end
   end

   // Next state: abort first, then start/exit handling, then tick-driven timing.
   always_comb begin
      state_nx      = state;
      phase_tmr_nx  = phase_tmr;
      rev_tmr_nx    = rev_tmr;
      dir_nx        = dir;
      coast_nx      = coast;
      abort_flag_nx = abort_flag;
      counted       = i_tick && !i_pause;
      active        = (state != ST_IDLE) && (state != ST_DONE) && (state <= ST_DONE);

      case (state)
         ST_FILL:  phase_last = FILL_LAST;
         ST_WASH:  phase_last = WASH_LAST;
         ST_RINSE: phase_last = RINSE_LAST;
         ST_DRAIN: phase_last = DRAIN_LAST;
         ST_SPIN:  phase_last = SPIN_LAST;
         default:  phase_last = '0;
      endcase

      if (i_abort && active) begin
         // Safe termination: (re)start DRAIN and remember not to spin afterwards.
         state_nx      = ST_DRAIN;
         phase_tmr_nx  = '0;
         rev_tmr_nx    = '0;
         dir_nx        = 1'b0;
         coast_nx      = 1'b0;
         abort_flag_nx = 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  state_nx      = ST_FILL;
                  phase_tmr_nx  = '0;
                  rev_tmr_nx    = '0;
                  dir_nx        = 1'b0;
                  coast_nx      = 1'b0;
                  abort_flag_nx = 1'b0;
               end
            end
            ST_DONE: begin
               // Wait for start to fall so a held start cannot retrigger.
               if (!i_start) state_nx = ST_IDLE;
            end
            ST_FILL, ST_WASH, ST_RINSE, ST_DRAIN, ST_SPIN: begin
               if (counted) begin
                  if (phase_tmr == phase_last) begin
                     // Phase entry clears everything, overriding the increment.
                     phase_tmr_nx = '0;
                     rev_tmr_nx   = '0;
                     dir_nx       = 1'b0;
                     coast_nx     = 1'b0;
                     case (state)
                        ST_FILL:  state_nx = ST_WASH;
                        ST_WASH:  state_nx = ST_RINSE;
                        ST_RINSE: state_nx = ST_DRAIN;
                        ST_DRAIN: begin
                           if (abort_flag) begin
                              state_nx      = ST_IDLE;
                              abort_flag_nx = 1'b0;
                           end else begin
                              state_nx = ST_SPIN;
                           end
                        end
                        default:  state_nx = ST_DONE;
                     endcase
                  end else begin
                     phase_tmr_nx = phase_tmr + TW'(1);
                     if ((state == ST_WASH) || (state == ST_RINSE)) begin
                        if (rev_tmr == REV_LAST) begin
                           rev_tmr_nx = '0;
                           dir_nx     = ~dir;
                           coast_nx   = 1'b1;
                        end else begin
                           rev_tmr_nx = rev_tmr + TW'(1);
                           coast_nx   = 1'b0;
                        end
                     end
                  end
               end
            end
            default: begin
               state_nx      = ST_IDLE;
               phase_tmr_nx  = '0;
               rev_tmr_nx    = '0;
               dir_nx        = 1'b0;
               coast_nx      = 1'b0;
               abort_flag_nx = 1'b0;
            end
         endcase
      end
   end

   // Output decode from the upcoming state and flags; pause silences actuators.
   always_comb begin
      duty_nx    = 8'd0;
      dir_out_nx = 1'b0;
      valve_nx   = 1'b0;
      pump_nx    = 1'b0;
      busy_nx    = (state_nx != ST_IDLE) && (state_nx != ST_DONE);
      done_nx    = (state_nx == ST_DONE) && (state != ST_DONE);
      case (state_nx)
         ST_FILL:  valve_nx = 1'b1;
         ST_WASH, ST_RINSE: begin
            duty_nx    = coast_nx ? 8'd0 : WASH_PWM;
            dir_out_nx = dir_nx;
         end
         ST_DRAIN: pump_nx = 1'b1;
         ST_SPIN: begin
            duty_nx = SPIN_PWM;
            pump_nx = 1'b1;
         end
         default: begin
            duty_nx = 8'd0;
         end
      endcase
      if (i_pause) begin
         duty_nx  = 8'd0;
         valve_nx = 1'b0;
         pump_nx  = 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_wash_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_wash_phase_sequencer
// Description : Randomized bench for wash_phase_sequencer, compared every
//               cycle against a phase/elapsed-tick reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wash_phase_sequencer;

   localparam int TW        = 16;
   localparam int FILL_T    = 2;
   localparam int WASH_T    = 4;
   localparam int RINSE_T   = 4;
   localparam int DRAIN_T   = 2;
   localparam int SPIN_T    = 3;
   localparam int REV_T     = 2;
   localparam int WASH_DUTY = 128;
   localparam int SPIN_DUTY = 230;
   localparam int N_CYC     = 6000;

   logic       sysclk = 1'b0;
   logic       rst_n  = 1'b1;
   logic       i_tick = 1'b0;
   logic       i_start = 1'b0;
   logic       i_pause = 1'b0;
   logic       i_abort = 1'b0;
   logic [2:0] o_phase;
   logic [7:0] o_duty;
   logic       o_dir;
   logic       o_valve;
   logic       o_pump;
   logic       o_busy;
   logic       o_done;

   int checks   = 0;
   int failures = 0;

   // Reference model: phase number, counted ticks spent in it, abort memory.
   int m_phase   = 0;
   int m_elapsed = 0;
   bit m_abort   = 0;
   bit m_pause   = 0;
   bit m_done    = 0;

   always #5 sysclk = ~sysclk;

   wash_phase_sequencer #(
      .TW(TW), .FILL_T(FILL_T), .WASH_T(WASH_T), .RINSE_T(RINSE_T),
      .DRAIN_T(DRAIN_T), .SPIN_T(SPIN_T), .REV_T(REV_T),
      .WASH_DUTY(WASH_DUTY), .SPIN_DUTY(SPIN_DUTY)
   ) dut (
      .sysclk (sysclk),
      .rst_n  (rst_n),
      .i_tick (i_tick),
      .i_start(i_start),
      .i_pause(i_pause),
      .i_abort(i_abort),
      .o_phase(o_phase),
      .o_duty (o_duty),
      .o_dir  (o_dir),
      .o_valve(o_valve),
      .o_pump (o_pump),
      .o_busy (o_busy),
      .o_done (o_done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int dur_of(input int ph);
      int d;
      case (ph)
         1: d = FILL_T;
         2: d = WASH_T;
         3: d = RINSE_T;
         4: d = DRAIN_T;
         5: d = SPIN_T;
         default: d = 1;
      endcase
      return (d < 1) ? 1 : d;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_elapsed = 0; m_abort = 0; m_pause = 0; m_done = 0;
   endtask

   // Advance the model by one clock edge using the inputs seen at that edge.
   task automatic model_step(input bit start, input bit pause, input bit abort, input bit tick);
      int prev;
      prev = m_phase;
      if (abort && m_phase >= 1 && m_phase <= 5) begin
         m_phase = 4; m_elapsed = 0; m_abort = 1;
      end else if (m_phase == 0) begin
         if (start) begin m_phase = 1; m_elapsed = 0; m_abort = 0; end
      end else if (m_phase == 6) begin
         if (!start) m_phase = 0;
      end else if (tick && !pause) begin
         m_elapsed++;
         if (m_elapsed >= dur_of(m_phase)) begin
            m_elapsed = 0;
            if (m_phase == 4 && m_abort) begin m_phase = 0; m_abort = 0; end
            else m_phase++;
         end
      end
      m_pause = pause;
      m_done  = (m_phase == 6) && (prev != 6);
   endtask

   task automatic compare_all();
      int duty, dir;
      bit wash;
      wash = (m_phase == 2 || m_phase == 3);
      duty = 0;
      dir  = 0;
      if (wash) begin
         // Direction flips every REV_T ticks; the tick period after a flip coasts.
         dir = (m_elapsed / REV_T) % 2;
         if (!m_pause) duty = (m_elapsed >= REV_T && m_elapsed % REV_T == 0) ? 0 : WASH_DUTY;
      end else if (m_phase == 5 && !m_pause) begin
         duty = SPIN_DUTY;
      end
      check("phase", 32'(o_phase), 32'(m_phase));
      check("duty",  32'(o_duty),  32'(duty));
      check("dir",   32'(o_dir),   32'(dir));
      check("valve", 32'(o_valve), 32'(!m_pause && m_phase == 1));
      check("pump",  32'(o_pump),  32'(!m_pause && (m_phase == 4 || m_phase == 5)));
      check("busy",  32'(o_busy),  32'(m_phase >= 1 && m_phase <= 5));
      check("done",  32'(o_done),  32'(m_done));
   endtask

   // Reset asserted between edges must clear outputs without waiting for a clock.
   task automatic async_reset();
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(posedge sysclk);
      #1;
      compare_all();
      rst_n = 1'b1;
   endtask

   initial begin
      int  pause_left = 0;
      int  idle_wait  = 2;
      bit  hold_start = 0;
      bit  spin_reset_done = 0;
      bit  pause_en, abort_en;

      #1 rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(posedge sysclk);
      #1;
      compare_all();
      rst_n = 1'b1;

      for (int cyc = 0; cyc < N_CYC; cyc++) begin
         pause_en = (cyc >= 400);
         abort_en = (cyc >= 2400);

         i_tick = ((cyc % 4) == 3);

         if (m_phase == 0) begin
            if (idle_wait > 0) begin
               idle_wait--;
               i_start = 1'b0;
            end else begin
               i_start    = 1'b1;
               hold_start = ($urandom_range(0, 2) == 0);
               idle_wait  = $urandom_range(1, 6);
            end
         end else if (m_phase == 6) begin
            i_start = hold_start && ($urandom_range(0, 7) != 0);
            if (!i_start) hold_start = 0;
         end else begin
            i_start = hold_start;
         end

         if (pause_left > 0) begin
            i_pause = 1'b1;
            pause_left--;
         end else begin
            i_pause = 1'b0;
            if (pause_en && m_phase >= 1 && m_phase <= 5 && $urandom_range(0, 59) == 0)
               pause_left = $urandom_range(4, 44);
         end

         i_abort = abort_en && ($urandom_range(0, 99) < 2);

         @(posedge sysclk);
         model_step(i_start, i_pause, i_abort, i_tick);
         #1;
         compare_all();

         if (abort_en && m_phase == 5 && (!spin_reset_done || $urandom_range(0, 199) == 0)) begin
            spin_reset_done = 1;
            pause_left = 0;
            i_pause = 1'b0;
            i_abort = 1'b0;
            async_reset();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wash_phase_sequencer.md
Name: wash_phase_sequencer

Overview:
- Sequences one complete wash cycle: FILL, WASH, RINSE, DRAIN, SPIN, DONE.
- Phase timing comes from a 1-cycle tick enable (i_tick) generated from the 100 kHz prescaled clock domain and presented synchronously on sysclk.
- Drives the PWM block's duty and direction inputs, plus the valve and pump enables.
- Sits between the control interface (start/pause/abort from the MCU link) and the PWM/memory datapath.

Parameters:
TW, 16, width of the phase timer and duration parameters
FILL_T, 100, FILL duration in ticks
WASH_T, 300, WASH duration in ticks
RINSE_T, 200, RINSE duration in ticks
DRAIN_T, 100, DRAIN duration in ticks
SPIN_T, 150, SPIN duration in ticks
REV_T, 50, WASH/RINSE direction-reversal period in ticks
WASH_DUTY, 128, 8-bit PWM duty in WASH and RINSE
SPIN_DUTY, 230, 8-bit PWM duty in SPIN

Ports:
sysclk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_tick  in  1  1-cycle timebase enable, sysclk-synchronous
i_start  in  1  level; sampled only in IDLE
i_pause  in  1  level; freezes timers while high
i_abort  in  1  1-cycle pulse; safe termination
o_phase  out  3  0 IDLE, 1 FILL, 2 WASH, 3 RINSE, 4 DRAIN, 5 SPIN, 6 DONE
o_duty  out  8  PWM duty command
o_dir  out  1  motor direction
o_valve  out  1  inlet valve enable
o_pump  out  1  drain pump enable
o_busy  out  1  high in every phase except IDLE and DONE
o_done  out  1  1-cycle pulse on entry to DONE

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; phase timer and reversal timer 0.
  - All outputs 0: o_phase=0, o_duty=0, o_dir=0, o_valve=0, o_pump=0, o_busy=0, o_done=0.
- All outputs are registered and a pure function of the state and flags. No combinational input-to-output path.
- IDLE: i_start=1 at a clock edge puts the state in FILL on that edge. Outputs reflect FILL in the following cycle.
- Phase timer:
  - Cleared on every phase entry.
  - Increments on a cycle with i_tick=1 and i_pause=0.
  - When i_tick=1, i_pause=0 and timer==DUR-1, the next edge enters the next phase.
  - A DUR of 0 is treated as 1.
  - Phase length is therefore exactly DUR unpaused ticks.
- Phase order: FILL→WASH→RINSE→DRAIN→SPIN→DONE.
- Per-phase outputs:
  - FILL: valve=1, duty=0.
  - WASH and RINSE: duty=WASH_DUTY, valve=0, pump=0.
  - DRAIN: pump=1, duty=0.
  - SPIN: pump=1, duty=SPIN_DUTY, dir=0.
  - DONE and IDLE: duty=0, valve=0, pump=0.
- Direction reversal (WASH and RINSE only):
  - Reversal timer counts unpaused ticks and wraps at REV_T-1.
  - On wrap, o_dir toggles.
  - On the single tick-period after a toggle (until the next counted tick), duty is forced to 0 as a coast gap.
  - Entering WASH or RINSE sets dir=0 and clears the reversal timer.
- Pause:
  - While i_pause=1, both timers freeze, duty=0, valve=0, pump=0.
  - State, o_phase, o_dir and o_busy hold.
  - Releasing pause restores the phase outputs on the next cycle.
- Abort (i_abort=1, priority over tick and pause):
  - From FILL, WASH or RINSE: enter DRAIN with the timer cleared and the abort flag set.
  - From DRAIN: the timer restarts and the flag is set.
  - From SPIN: enter DRAIN with the flag set.
  - A DRAIN that completes with the flag set goes to IDLE (flag cleared), not SPIN. No o_done pulse.
  - Abort in IDLE or DONE is ignored.
- DONE:
  - o_done=1 for exactly the entry cycle.
  - Stay in DONE until i_start=0, then go to IDLE.
  - A held start never retriggers a cycle.
- Tick and phase-end are evaluated in the same cycle; the timer clearing on phase entry wins over the increment.
- rst_n assertion mid-cycle returns to the reset state immediately, outputs 0.

Test Plan:
- Parameters FILL_T=2, WASH_T=4, RINSE_T=4, DRAIN_T=2, SPIN_T=3, REV_T=2; i_tick every 4 cycles; pulse start. Expect:
  - o_phase sequence 1,2,3,4,5,6,0.
  - Phase dwell of 2,4,4,2,3 ticks.
  - o_done high for exactly 1 cycle.
  - o_valve only in phase 1; o_pump only in phases 4 and 5.
- WASH with REV_T=2 → o_dir toggles every 2 ticks. o_duty is 0 for the tick-period after each toggle, else 128.
- Pause for 10 ticks in WASH at timer=1 → o_duty=0, o_phase stays 2. After release, WASH lasts 3 more ticks.
- Abort pulse in RINSE → o_phase=4 on the next cycle, DRAIN lasts 2 ticks, then o_phase=0 and o_done never asserts. Repeat abort during SPIN → same result.
- Hold i_start=1 throughout a full run → DONE persists until start falls, then IDLE, with no second cycle.
- Assert rst_n=0 mid-SPIN asynchronously (between edges) → all outputs 0 immediately. After release, o_phase=0 until a new start.
